// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller for the 1x3 router; optional drop counter under ROUTER_FSM_DROP_CNT_EN
module router_fsm #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy
`ifdef ROUTER_FSM_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);
  typedef enum logic [2:0] {DA, LFD, LD, FFS, LAF, LP, CPE, WTE} state_t;
  localparam logic [ADDR_W-1:0] BAD = ADDR_W'(3);
  state_t state, next;
  logic [ADDR_W-1:0] addr;
  logic in_empty, sel_empty, sel_soft, soft_exit;
  function automatic logic pick(input logic [ADDR_W-1:0] a, input logic [2:0] v);
    return (a == ADDR_W'(0)) ? v[0] : (a == ADDR_W'(1)) ? v[1] : (a == ADDR_W'(2)) ? v[2] : 1'b0;
  endfunction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DA;
      addr  <= '0;
    end else begin
      state <= next;
      if (state == DA && pkt_valid) addr <= data_in;
    end
  end
  // DA decodes the live header; every later state works off the latched address
  always_comb begin
    in_empty  = pick(data_in, {fifo_empty_2, fifo_empty_1, fifo_empty_0});
    sel_empty = pick(addr, {fifo_empty_2, fifo_empty_1, fifo_empty_0});
    sel_soft  = pick(addr, {soft_reset_2, soft_reset_1, soft_reset_0});
    soft_exit = state != DA && sel_soft;
    next = state;
    case (state)
      DA:  if (pkt_valid && data_in < BAD) next = in_empty ? LFD : WTE;
      LFD: next = LD;
      LD:  next = fifo_full ? FFS : !pkt_valid ? LP : LD;
      FFS: next = fifo_full ? FFS : LAF;
      LAF: next = parity_done ? DA : low_pkt_valid ? LP : LD;
      LP:  next = CPE;
      CPE: next = fifo_full ? FFS : DA;
      WTE: next = sel_empty ? LFD : WTE;
      default: next = DA;
    endcase
    if (soft_exit) next = DA;
    detect_add    = state == DA;
    lfd_state     = state == LFD;
    ld_state      = state == LD;
    laf_state     = state == LAF;
    full_state    = state == FFS;
    rst_int_reg   = state == CPE;
    write_enb_reg = state == LFD || state == LD || state == LAF || state == LP;
    busy          = state != DA && state != LD;
  end
`ifdef ROUTER_FSM_DROP_CNT_EN
  logic drop;
  assign drop = (state == DA && pkt_valid && data_in == BAD) || soft_exit;
  always_ff @(posedge clk) begin
    if (!resetn) drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed self-checking bench for router_fsm
module tb_router_fsm;
  logic clk = 0, resetn = 0, pkt_valid = 0, fifo_full = 0, parity_done = 0, low_pkt_valid = 0;
  logic [1:0] data_in = 0;
  logic fifo_empty_0 = 0, fifo_empty_1 = 0, fifo_empty_2 = 0;
  logic soft_reset_0 = 0, soft_reset_1 = 0, soft_reset_2 = 0;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy;
  logic [7:0] o;
  int tests = 0, fails = 0;
  logic lfd_seen;
  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  localparam logic [7:0] O_DA = 8'b1000_0000, O_LFD = 8'b0100_0011, O_LD = 8'b0010_0010,
    O_LAF = 8'b0001_0011, O_FFS = 8'b0000_1001, O_LP = 8'b0000_0011, O_CPE = 8'b0000_0101,
    O_WTE = 8'b0000_0001;
`ifdef ROUTER_FSM_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  router_fsm #(.ADDR_W(2)) dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy)
`ifdef ROUTER_FSM_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  assign o = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy};
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  initial begin
    tick;
    chk("reset", o, O_DA);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk("reset_cnt", drop_cnt, 8'd0);
`endif
    resetn = 1; pkt_valid = 1; data_in = 1; fifo_empty_1 = 1;
    tick; chk("hdr1_lfd", o, O_LFD);
    tick; chk("hdr1_ld", o, O_LD);
    tick; chk("pay2_ld", o, O_LD);
    tick; chk("pay3_ld", o, O_LD);
    pkt_valid = 0;
    tick; chk("lp", o, O_LP);
    tick; chk("cpe", o, O_CPE);
    tick; chk("cpe_to_da", o, O_DA);
    pkt_valid = 1; data_in = 0; fifo_empty_0 = 1;
    tick; chk("hdr0_lfd", o, O_LFD);
    tick; chk("hdr0_ld", o, O_LD);
    fifo_full = 1;
    for (int i = 0; i < 4; i++) begin
      tick; chk("ffs_hold", o, O_FFS);
    end
    fifo_full = 0;
    tick; chk("laf", o, O_LAF);
    tick; chk("laf_to_ld", o, O_LD);
    fifo_full = 1;
    tick; chk("ffs2", o, O_FFS);
    fifo_full = 0; low_pkt_valid = 1;
    tick; chk("laf2", o, O_LAF);
    tick; chk("laf_low_to_lp", o, O_LP);
    low_pkt_valid = 0; pkt_valid = 0; fifo_full = 1;
    tick; chk("cpe2", o, O_CPE);
    tick; chk("cpe_full_to_ffs", o, O_FFS);
    fifo_full = 0; parity_done = 1;
    tick; chk("laf3", o, O_LAF);
    tick; chk("laf_parity_to_da", o, O_DA);
    parity_done = 0; pkt_valid = 1; data_in = 2; fifo_empty_2 = 0;
    for (int i = 0; i < 5; i++) begin
      tick; chk("wte_hold", o, O_WTE);
    end
    fifo_empty_2 = 1;
    tick; chk("wte_to_lfd", o, O_LFD);
    tick; chk("hdr2_ld", o, O_LD);
    pkt_valid = 0;
    tick; chk("lp2", o, O_LP);
    tick; chk("cpe3", o, O_CPE);
    tick; chk("da3", o, O_DA);
    pkt_valid = 1; data_in = 0;
    tick; chk("hdr0b_lfd", o, O_LFD);
    tick; chk("hdr0b_ld", o, O_LD);
    soft_reset_1 = 1;
    tick; chk("soft_other", o, O_LD);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk("soft_other_cnt", drop_cnt, 8'd0);
`endif
    soft_reset_1 = 0; soft_reset_0 = 1;
    tick; chk("soft_sel", o, O_DA);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk("soft_sel_cnt", drop_cnt, 8'd1);
`endif
    soft_reset_0 = 0; data_in = 3; lfd_seen = 0;
    tick; chk("bad_hdr", o, O_DA);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk("bad_hdr_cnt", drop_cnt, 8'd2);
`endif
    for (int i = 0; i < 299; i++) begin
      tick;
      lfd_seen |= lfd_state | ~detect_add;
    end
    chk("bad_hdr_stay", {7'd0, lfd_seen}, 8'd0);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk("cnt_sat", drop_cnt, 8'd255);
`endif
    data_in = 1;
    tick; chk("hdr1b_lfd", o, O_LFD);
    tick; chk("hdr1b_ld", o, O_LD);
    resetn = 0; soft_reset_1 = 1;
    tick; chk("reset_mid_ld", o, O_DA);
`ifdef ROUTER_FSM_DROP_CNT_EN
    chk("reset_cnt_clr", drop_cnt, 8'd0);
`endif
    resetn = 1; soft_reset_1 = 0; pkt_valid = 0;
    tick; chk("idle_da", o, O_DA);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
